data_island_packet_assembler: RTL and testbench

- Sits directly downstream of the HDMI packet picker.
- Takes the selected packet's 24-bit header and four 56-bit subpackets, appends BCH parity, and serialises the packet over 32 pixel clocks as a 9-bit data-island word per clock.
- Owns the data-island pixel counter and generates the packet_enable pulse that tells the picker to load the next packet.
- Output feeds the TERC4 channel encoders.

---
 rtl/hdmi_packet_pkg.sv | 24 ++
 rtl/bch_ecc_serial.sv | 39 +++
 rtl/data_island_packet_assembler.sv | 114 +++++++++++
 tb/tb_data_island_packet_assembler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island packet constants, subpacket bundle type and the serial BCH step.
// Combinational helpers only; no state lives here.
package hdmi_packet_pkg;

  localparam int PACKET_CYCLES = 32;
  localparam int HEADER_BITS   = 24;
  localparam int SUB_BITS      = 56;
  localparam int SUB_LANES     = 4;
  localparam int ECC_BITS      = 8;
  localparam logic [ECC_BITS-1:0] BCH_POLY = 8'h83;

  // Lane k occupies [k]; bit 0 of each lane is SB0[0].
  typedef logic [SUB_LANES-1:0][SUB_BITS-1:0] sub_array_t;

  function automatic logic [ECC_BITS-1:0] bch_step(
    input logic [ECC_BITS-1:0] ecc,
    input logic                bit_i
  );
    logic fb;
    fb = ecc[0] ^ bit_i;
    return (ecc >> 1) ^ (fb ? BCH_POLY : '0);
  endfunction

endpackage

// File: rtl/bch_ecc_serial.sv
// Serial BCH parity accumulator, one or two message bits per clock, LSB-first.
// ecc_o is the registered remainder; clear_i restarts from zero on the same cycle it advances.
module bch_ecc_serial
  import hdmi_packet_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic                      advance_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  output logic [ECC_BITS-1:0]       ecc_o
);

  logic [ECC_BITS-1:0] ecc_q;
  logic [ECC_BITS-1:0] ecc_d;

  always_comb begin
    ecc_d = clear_i ? '0 : ecc_q;
    if (advance_i) begin
      // Lower-indexed bit is the earlier one in the message stream.
      for (int b = 0; b < BITS_PER_CYCLE; b++) begin
        ecc_d = bch_step(ecc_d, bits_i[b]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ecc_q <= '0;
    end else begin
      ecc_q <= ecc_d;
    end
  end

  assign ecc_o = ecc_q;

endmodule

// File: rtl/data_island_packet_assembler.sv
// Captures one header + four subpackets, appends BCH parity and serialises over 32 pixels.
// packet_data lags the counter by one clock; no backpressure, upstream reloads on packet_enable.
module data_island_packet_assembler
  import hdmi_packet_pkg::*;
(
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   data_island_period,
  input  logic [HEADER_BITS-1:0] header,
  input  logic [SUB_BITS-1:0]    sub_0,
  input  logic [SUB_BITS-1:0]    sub_1,
  input  logic [SUB_BITS-1:0]    sub_2,
  input  logic [SUB_BITS-1:0]    sub_3,
  output logic [4:0]             packet_pixel_counter,
  output logic                   packet_enable,
  output logic [8:0]             packet_data
);

  logic [4:0]             counter_q, counter_d;
  logic [HEADER_BITS-1:0] hdr_q, hdr_d, hdr_sel;
  sub_array_t             sub_q, sub_d, sub_in, sub_sel;
  logic [8:0]             data_q, data_d;

  logic                   first_pixel;
  logic                   start;
  logic                   hdr_in_body;
  logic                   sub_in_body;
  logic                   hdr_bit;
  logic [SUB_LANES-1:0]   sub_even;
  logic [SUB_LANES-1:0]   sub_odd;
  logic [ECC_BITS-1:0]    hdr_ecc;
  logic [ECC_BITS-1:0]    sub_ecc [SUB_LANES];

  assign sub_in      = {sub_3, sub_2, sub_1, sub_0};
  assign first_pixel = (counter_q == 5'd0);
  assign start       = data_island_period && first_pixel;
  assign hdr_in_body = (counter_q < 5'(HEADER_BITS));
  assign sub_in_body = (counter_q < 5'(SUB_BITS / 2));

  // Pixel 0 reads straight from the picker so the shadow copy never costs a cycle.
  always_comb begin
    hdr_sel = first_pixel ? header : hdr_q;
    sub_sel = first_pixel ? sub_in : sub_q;
    hdr_bit = hdr_sel[counter_q];
    for (int k = 0; k < SUB_LANES; k++) begin
      sub_even[k] = sub_sel[k][{counter_q, 1'b0}];
      sub_odd[k]  = sub_sel[k][{counter_q, 1'b1}];
    end
  end

  bch_ecc_serial #(
    .BITS_PER_CYCLE(1)
  ) u_hdr_ecc (
    .clk_i    (clk_pixel),
    .reset_i  (reset),
    .clear_i  (first_pixel),
    .advance_i(data_island_period && hdr_in_body),
    .bits_i   (hdr_bit),
    .ecc_o    (hdr_ecc)
  );

  for (genvar k = 0; k < SUB_LANES; k++) begin : g_sub_ecc
    bch_ecc_serial #(
      .BITS_PER_CYCLE(2)
    ) u_sub_ecc (
      .clk_i    (clk_pixel),
      .reset_i  (reset),
      .clear_i  (first_pixel),
      .advance_i(data_island_period && sub_in_body),
      .bits_i   ({sub_odd[k], sub_even[k]}),
      .ecc_o    (sub_ecc[k])
    );
  end

  always_comb begin
    counter_d = data_island_period ? counter_q + 5'd1 : 5'd0;
    hdr_d     = start ? header : hdr_q;
    sub_d     = start ? sub_in : sub_q;
    data_d    = '0;
    if (data_island_period) begin
      data_d[0] = hdr_in_body ? hdr_bit : hdr_ecc[counter_q[2:0]];
      for (int k = 0; k < SUB_LANES; k++) begin
        if (sub_in_body) begin
          data_d[1+k] = sub_even[k];
          data_d[5+k] = sub_odd[k];
        end else begin
          data_d[1+k] = sub_ecc[k][{counter_q[1:0], 1'b0}];
          data_d[5+k] = sub_ecc[k][{counter_q[1:0], 1'b1}];
        end
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      counter_q <= '0;
      hdr_q     <= '0;
      sub_q     <= '0;
      data_q    <= '0;
    end else begin
      counter_q <= counter_d;
      hdr_q     <= hdr_d;
      sub_q     <= sub_d;
      data_q    <= data_d;
    end
  end

  // Reset wins over the island flag, so an aborted packet never requests a successor.
  assign packet_enable        = data_island_period && !reset &&
                                (counter_q == 5'(PACKET_CYCLES - 1));
  assign packet_pixel_counter = counter_q;
  assign packet_data          = data_q;

endmodule

// File: tb/tb_data_island_packet_assembler.sv
// Scoreboard bench: expected words are queued at drive time and popped one clock later.
module tb_data_island_packet_assembler;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic        data_island_period;
  logic [23:0] header;
  logic [55:0] sub_0, sub_1, sub_2, sub_3;
  logic [4:0]  packet_pixel_counter;
  logic        packet_enable;
  logic [8:0]  packet_data;

  always #5 clk_pixel = ~clk_pixel;

  data_island_packet_assembler dut (
    .clk_pixel           (clk_pixel),
    .reset               (reset),
    .data_island_period  (data_island_period),
    .header              (header),
    .sub_0               (sub_0),
    .sub_1               (sub_1),
    .sub_2               (sub_2),
    .sub_3               (sub_3),
    .packet_pixel_counter(packet_pixel_counter),
    .packet_enable       (packet_enable),
    .packet_data         (packet_data)
  );

  typedef struct {
    logic [8:0] dat;
    int         idx;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_cnt    = 0;
  logic [8:0] pkt [32];
  logic [7:0] got_hdr_ecc;
  logic [7:0] got_sub2_ecc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Golden serial BCH over the first n bits of v, LSB first.
  function automatic logic [7:0] ref_ecc(input logic [55:0] v, input int n);
    logic [7:0] e;
    logic       fb;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = e[0] ^ v[i];
      e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  // Whole-packet expectation built from the inputs present at capture.
  task automatic build_packet();
    logic [55:0] s  [4];
    logic [7:0]  se [4];
    logic [7:0]  he;
    s[0] = sub_0; s[1] = sub_1; s[2] = sub_2; s[3] = sub_3;
    he = ref_ecc({32'd0, header}, 24);
    for (int k = 0; k < 4; k++) se[k] = ref_ecc(s[k], 56);
    for (int i = 0; i < 32; i++) begin
      pkt[i]    = 9'd0;
      pkt[i][0] = (i < 24) ? header[i] : he[i-24];
      for (int k = 0; k < 4; k++) begin
        if (i < 28) begin
          pkt[i][1+k] = s[k][2*i];
          pkt[i][5+k] = s[k][2*i+1];
        end else begin
          pkt[i][1+k] = se[k][2*(i-28)];
          pkt[i][5+k] = se[k][2*(i-28)+1];
        end
      end
    end
  endtask

  task automatic randomize_inputs();
    header = 24'($urandom);
    sub_0  = 56'({$urandom, $urandom});
    sub_1  = 56'({$urandom, $urandom});
    sub_2  = 56'({$urandom, $urandom});
    sub_3  = 56'({$urandom, $urandom});
  endtask

  // Called just after a falling edge: drive, check, queue expectation, advance one clock.
  task automatic step(input logic per, input logic rst);
    exp_t e;
    data_island_period = per;
    reset              = rst;
    #1;
    chk("counter", 64'(packet_pixel_counter), 64'(m_cnt));
    chk("enable", 64'(packet_enable), 64'(per && !rst && (m_cnt == 31)));
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got no entry expected one at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk("data", 64'(packet_data), 64'(e.dat));
      if (e.idx >= 24) got_hdr_ecc[e.idx-24] = packet_data[0];
      if (e.idx >= 28) begin
        got_sub2_ecc[2*(e.idx-28)]   = packet_data[3];
        got_sub2_ecc[2*(e.idx-28)+1] = packet_data[7];
      end
    end
    if (per && !rst) begin
      if (m_cnt == 0) build_packet();
      e.dat = pkt[m_cnt];
      e.idx = m_cnt;
    end else begin
      e.dat = 9'd0;
      e.idx = -1;
    end
    sb.push_back(e);
    @(posedge clk_pixel);
    m_cnt = rst ? 0 : (per ? (m_cnt + 1) % 32 : 0);
    @(negedge clk_pixel);
  endtask

  initial begin
    reset              = 1'b1;
    data_island_period = 1'b0;
    header             = '0;
    sub_0 = '0; sub_1 = '0; sub_2 = '0; sub_3 = '0;
    got_hdr_ecc  = '0;
    got_sub2_ecc = '0;
    @(negedge clk_pixel);
    sb.push_back('{dat: 9'd0, idx: -1});
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);

    // All-zero island, two packets.
    repeat (64) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);

    // Single header bit.
    header = 24'h000001;
    repeat (32) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    chk("hdr_ecc", 64'(got_hdr_ecc), 64'h4A);

    // Single subpacket-2 bit.
    header = '0;
    sub_2  = 56'h1;
    repeat (32) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    chk("sub2_ecc", 64'(got_sub2_ecc), 64'(ref_ecc(56'h1, 56)));

    // Back-to-back random packets with upstream churn mid-packet.
    for (int c = 0; c < 64; c++) begin
      if (m_cnt == 0 || m_cnt == 5) randomize_inputs();
      step(1'b1, 1'b0);
    end
    repeat (2) step(1'b0, 1'b0);

    // Island dropped at pixel 17, resumed 4 cycles later.
    randomize_inputs();
    repeat (17) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    randomize_inputs();
    repeat (32) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);

    // Reset pulsed at pixel 9 while the island is still high.
    randomize_inputs();
    repeat (9) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    randomize_inputs();
    repeat (32) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
